// File: rtl/harness_pkg.sv
// Shared types and the round-robin pick helper for the harness fan-in.
package harness_pkg;

  localparam int NUM_LANES = 4;

  typedef logic [1:0] lane_t;

  // First requesting lane at or after rr, searching upward mod NUM_LANES.
  // Falls back to rr when nothing requests; callers gate on |req.
  function automatic lane_t rr_pick(input logic [NUM_LANES-1:0] req, input lane_t rr);
    lane_t pick;
    lane_t idx;
    pick = rr;
    // Walk downward so the closest lane to rr overwrites farther ones.
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      idx = rr + lane_t'(i);
      if (req[idx]) pick = idx;
    end
    return pick;
  endfunction

endpackage

// File: rtl/harness_lane_fifo.sv
// Per-lane result FIFO. The lane has no backpressure, so a push into a full
// FIFO is dropped and latched into a sticky overflow flag. A pop on the same
// edge frees the slot, letting the push through.
module harness_lane_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             ovf_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q;
  logic             push_ok;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign data_o  = mem_q[rd_q];
  assign ovf_o   = ovf_q;
  assign push_ok = push_i && (!full_o || pop_i);

  // Occupancy next-state from the push/pop pair.
  always_comb begin
    cnt_d = cnt_q;
    case ({push_ok, pop_i})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= data_i;
  end

  // Pointers, count and sticky overflow; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (push_ok) wr_q <= wr_q + AW'(1);
      if (pop_i)   rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_d;
      if (push_i && !push_ok) ovf_q <= 1'b1;
    end
  end

endmodule

// File: rtl/harness_fanin.sv
// Fan-in collector: four per-lane FIFOs merged round-robin into a single
// registered valid/ready stream tagged with the source lane.
// Optional per-lane handshake counters under HARNESS_FANIN_STATS_EN.
module harness_fanin
  import harness_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_LANES-1:0] i_valid,
  input  logic [WIDTH-1:0]     i_data0,
  input  logic [WIDTH-1:0]     i_data1,
  input  logic [WIDTH-1:0]     i_data2,
  input  logic [WIDTH-1:0]     i_data3,
  output logic                 o_valid,
  input  logic                 o_ready,
  output logic [WIDTH-1:0]     o_data,
  output lane_t                o_lane,
  output logic [NUM_LANES-1:0] o_ovf,
`ifdef HARNESS_FANIN_STATS_EN
  output logic [NUM_LANES*16-1:0] o_cnt,
`endif
  output logic                 o_idle
);

  logic [NUM_LANES-1:0][WIDTH-1:0] lane_din, lane_dout;
  logic [NUM_LANES-1:0]            full, empty, pop;
  logic [NUM_LANES-1:0]            req;
  lane_t                           grant;
  logic                            load;

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  lane_t            lane_q, lane_d;
  lane_t            rr_q, rr_d;

  assign lane_din = {i_data3, i_data2, i_data1, i_data0};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    harness_lane_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (i_valid[g]),
      .pop_i   (pop[g]),
      .data_i  (lane_din[g]),
      .data_o  (lane_dout[g]),
      .full_o  (full[g]),
      .empty_o (empty[g]),
      .ovf_o   (o_ovf[g])
    );
  end

  // Arbitration and output-register next state; the granted lane pops on load.
  always_comb begin
    req     = ~empty;
    grant   = rr_pick(req, rr_q);
    load    = (!valid_q || o_ready) && (|req);
    pop     = '0;
    valid_d = valid_q;
    data_d  = data_q;
    lane_d  = lane_q;
    rr_d    = rr_q;
    if (load) begin
      pop[grant] = 1'b1;
      valid_d    = 1'b1;
      data_d     = lane_dout[grant];
      lane_d     = grant;
      rr_d       = grant + lane_t'(1);
    end else if (o_ready) begin
      valid_d = 1'b0;
    end
  end

  // Output register and round-robin pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      lane_q  <= '0;
      rr_q    <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      lane_q  <= lane_d;
      rr_q    <= rr_d;
    end
  end

  assign o_valid = valid_q;
  assign o_data  = data_q;
  assign o_lane  = lane_q;
  assign o_idle  = (&empty) && !valid_q;

`ifdef HARNESS_FANIN_STATS_EN
  logic [NUM_LANES-1:0][15:0] cnt_q;

  // Saturating per-lane count of accepted output words.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (valid_q && o_ready && (cnt_q[lane_q] != 16'hFFFF)) begin
      cnt_q[lane_q] <= cnt_q[lane_q] + 16'd1;
    end
  end

  assign o_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_harness_fanin.sv
// Directed bench for harness_fanin: round-robin order, backpressure and
// overflow, full-with-pop, fairness, mid-run reset, optional stats counters.
module tb_harness_fanin;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] i_valid;
  logic [7:0] i_data0, i_data1, i_data2, i_data3;
  logic       o_valid, o_ready, o_idle;
  logic [7:0] o_data;
  logic [1:0] o_lane;
  logic [3:0] o_ovf;
`ifdef HARNESS_FANIN_STATS_EN
  logic [63:0] o_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  harness_fanin #(.WIDTH(8), .DEPTH(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .i_valid (i_valid),
    .i_data0 (i_data0),
    .i_data1 (i_data1),
    .i_data2 (i_data2),
    .i_data3 (i_data3),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .o_data  (o_data),
    .o_lane  (o_lane),
    .o_ovf   (o_ovf),
`ifdef HARNESS_FANIN_STATS_EN
    .o_cnt   (o_cnt),
`endif
    .o_idle  (o_idle)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_out(input string tag, input logic [1:0] l, input logic [7:0] d);
    chk({tag, ".valid"}, 32'(o_valid), 32'd1);
    chk({tag, ".lane"},  32'(o_lane),  32'(l));
    chk({tag, ".data"},  32'(o_data),  32'(d));
  endtask

  initial begin
    logic [7:0] t1d [4];
    t1d = '{8'h11, 8'h22, 8'h33, 8'h44};

    reset = 1'b1; i_valid = '0; o_ready = 1'b1;
    i_data0 = '0; i_data1 = '0; i_data2 = '0; i_data3 = '0;
    tick(); tick();
    chk("rst.valid", 32'(o_valid), 32'd0);
    chk("rst.data",  32'(o_data),  32'd0);
    chk("rst.lane",  32'(o_lane),  32'd0);
    chk("rst.ovf",   32'(o_ovf),   32'd0);
    chk("rst.idle",  32'(o_idle),  32'd1);

    // 1: all lanes push twice; round-robin 0..3 repeats, valid two cycles on.
    i_valid = 4'hF;
    i_data0 = 8'h11; i_data1 = 8'h22; i_data2 = 8'h33; i_data3 = 8'h44;
    reset = 1'b0;
    tick();
    chk("t1.lat.valid", 32'(o_valid), 32'd0);
    chk("t1.lat.idle",  32'(o_idle),  32'd0);
    tick();
    i_valid = '0;
    exp_out("t1.w0", 2'd0, 8'h11);
    for (int k = 1; k < 8; k++) begin
      tick();
      exp_out("t1.w", 2'(k % 4), t1d[k % 4]);
    end
    tick();
    chk("t1.end.valid", 32'(o_valid), 32'd0);
    chk("t1.end.idle",  32'(o_idle),  32'd1);
    chk("t1.end.ovf",   32'(o_ovf),   32'd0);

    // 2: backpressure on lane 2; A0 held, A1..A4 buffered, A5 dropped.
    o_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      i_valid = 4'b0100;
      i_data2 = 8'hA0 + 8'(k);
      tick();
      if (k >= 1) exp_out("t2.hold", 2'd2, 8'hA0);
    end
    i_valid = '0;
    for (int k = 0; k < 4; k++) begin
      tick();
      exp_out("t2.hold", 2'd2, 8'hA0);
    end
    chk("t2.ovf", 32'(o_ovf), 32'h4);
    o_ready = 1'b1;
    for (int k = 1; k < 5; k++) begin
      tick();
      exp_out("t2.drain", 2'd2, 8'hA0 + 8'(k));
    end
    tick();
    chk("t2.end.valid", 32'(o_valid), 32'd0);

    // 3: lane 1 full while presenting; push of 5E rides on the handshake pop.
    o_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      i_valid = 4'b0010;
      i_data1 = 8'h10 + 8'(k);
      tick();
    end
    exp_out("t3.pre", 2'd1, 8'h10);
    i_valid = 4'b0010; i_data1 = 8'h5E; o_ready = 1'b1;
    tick();
    i_valid = '0;
    exp_out("t3.w11", 2'd1, 8'h11);
    chk("t3.ovf", 32'(o_ovf), 32'h4);
    tick(); exp_out("t3.w12", 2'd1, 8'h12);
    tick(); exp_out("t3.w13", 2'd1, 8'h13);
    tick(); exp_out("t3.w14", 2'd1, 8'h14);
    tick(); exp_out("t3.w5e", 2'd1, 8'h5E);
    tick();
    chk("t3.end.valid", 32'(o_valid), 32'd0);

    // 4: lanes 0 and 3 always valid; rr sits at 2, so grants go 3,0,3,0...
    for (int k = 0; k < 9; k++) begin
      i_valid = 4'b1001;
      i_data0 = 8'(k);
      i_data3 = 8'h30 + 8'(k);
      tick();
      if (k >= 1) begin
        if (k % 2 == 1) exp_out("t4.l3", 2'd3, 8'h30 + 8'((k - 1) / 2));
        else            exp_out("t4.l0", 2'd0, 8'((k - 2) / 2));
      end
    end

    // 5: fill every lane with o_valid high, then reset mid-run.
    o_ready = 1'b0;
    i_valid = 4'hF;
    i_data0 = 8'h55; i_data1 = 8'h55; i_data2 = 8'h55; i_data3 = 8'h55;
    tick();
    i_valid = '0;
    tick();
    chk("t5.pre.valid", 32'(o_valid), 32'd1);
    reset = 1'b1;
    #1;
    chk("t5.rst.valid", 32'(o_valid), 32'd0);
    chk("t5.rst.ovf",   32'(o_ovf),   32'd0);
    chk("t5.rst.idle",  32'(o_idle),  32'd1);
    chk("t5.rst.lane",  32'(o_lane),  32'd0);
    tick();
    reset = 1'b0; o_ready = 1'b1;
    i_valid = 4'b0100; i_data2 = 8'h77;
    tick();
    i_valid = '0;
    chk("t5.lat.valid", 32'(o_valid), 32'd0);
    tick();
    exp_out("t5.w77", 2'd2, 8'h77);
    tick();
    chk("t5.end.idle", 32'(o_idle), 32'd1);

`ifdef HARNESS_FANIN_STATS_EN
    // 6: saturate lane 0's handshake counter; other lanes stay at zero.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6.rst.lo", o_cnt[31:0],  32'd0);
    chk("t6.rst.hi", o_cnt[63:32], 32'd0);
    i_valid = 4'b0001; i_data0 = 8'h01;
    for (int k = 0; k < 70000; k++) tick();
    i_valid = '0;
    chk("t6.cnt0",   32'(o_cnt[15:0]), 32'hFFFF);
    chk("t6.cnt1",   32'(o_cnt[31:16]), 32'd0);
    chk("t6.cnt23",  o_cnt[63:32], 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
